pwm_demod: RTL and testbench



---
 rtl/pwm_demod_pkg.sv | 30 +++
 rtl/pwm_sync_edge.sv | 39 +++
 rtl/pwm_demod.sv | 157 +++++++++++++++
 tb/tb_pwm_demod.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_demod_pkg.sv
// Shared types, default parameter values and helpers for the PWM demodulator.
//   state_e  : period tracker state (hunting for the first edge, or tracking periods)
//   sat_add  : add one input bit to a high-time count, saturating at 2^pw - 1
package pwm_demod_pkg;

    typedef enum logic {
        StHunt,
        StTrack
    } state_e;

    localparam int unsigned PwDefault         = 16;
    localparam int unsigned AvgLog2Default    = 8;
    localparam int unsigned SyncStagesDefault = 2;

    // The 16th high cycle of a stuck-high period would give 2^pw, which does not
    // fit in a pw-bit sample, so clamp to the largest representable duty.
    function automatic logic [31:0] sat_add(input logic [31:0]   hi,
                                            input logic          b,
                                            input int unsigned   pw);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, hi} + {32'd0, b};
        max_v = (33'd1 << pw) - 33'd1;
        if (sum > max_v) begin
            return max_v[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Input conditioning for the PWM demodulator: multi-flop synchronizer followed by
// a one-cycle delay used for rising-edge detection.
//   clk, rst_n : clock, asynchronous active-low reset (all flops clear to 0)
//   pwm_in     : asynchronous PWM stream
//   pwm_s      : synchronized stream (SYNC_STAGES flops after pwm_in)
//   pwm_rise   : pwm_s & ~(pwm_s delayed by one cycle)
// SYNC_STAGES must be at least 2.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pwm_s,
    output logic pwm_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_d_q, pwm_d_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_d_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pwm_d_q <= pwm_d_d;
        end
    end

    assign pwm_s    = sync_q[SYNC_STAGES-1];
    assign pwm_rise = pwm_s & ~pwm_d_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: measures the high time of each 2^PW-clock period of an incoming
// PWM stream and averages 2^AVG_LOG2 consecutive samples to recover a dithered
// duty target with AVG_LOG2 extra fractional bits.
//   clk, rst_n   : PWM-rate clock, asynchronous active-low reset
//   pwm_in       : asynchronous PWM stream, high at the start of each period
//   sample       : high-time count of the last complete period
//   sample_valid : one-cycle pulse when sample updates
//   avg          : sum of the last 2^AVG_LOG2 samples (mean with AVG_LOG2 fraction bits)
//   avg_valid    : one-cycle pulse when avg updates
//   locked       : a complete aligned period has been seen since reset or last slip
//   slip         : one-cycle pulse when a rising edge arrives off the period boundary
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int unsigned PW          = PwDefault,
    parameter int unsigned AVG_LOG2    = AvgLog2Default,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwm_in,
    output logic [PW-1:0]          sample,
    output logic                   sample_valid,
    output logic [PW+AVG_LOG2-1:0] avg,
    output logic                   avg_valid,
    output logic                   locked,
    output logic                   slip
);

    localparam int unsigned AW = PW + AVG_LOG2;

    logic pwm_s;
    logic pwm_rise;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_in  (pwm_in),
        .pwm_s   (pwm_s),
        .pwm_rise(pwm_rise)
    );

    state_e              state_q, state_d;
    logic [PW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       hi_q, hi_d;
    logic [PW-1:0]       sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                locked_q, locked_d;
    logic                slip_q, slip_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] n_q, n_d;
    logic [AW-1:0]       avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                clear_avg;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hi_d           = hi_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        locked_d       = locked_q;
        slip_d         = 1'b0;
        clear_avg      = 1'b0;

        unique case (state_q)
            StHunt: begin
                cnt_d = '0;
                hi_d  = '0;
                if (pwm_rise) begin
                    state_d = StTrack;
                    cnt_d   = PW'(1);
                    hi_d    = PW'(1);
                end
            end
            StTrack: begin
                if (pwm_rise && (cnt_q != '0)) begin
                    // Edge inside a period: drop the partial period and realign to it.
                    slip_d    = 1'b1;
                    locked_d  = 1'b0;
                    clear_avg = 1'b1;
                    cnt_d     = PW'(1);
                    hi_d      = PW'(1);
                end else if (cnt_q == '1) begin
                    sample_d       = PW'(sat_add(32'(hi_q), pwm_s, PW));
                    sample_valid_d = 1'b1;
                    locked_d       = 1'b1;
                    cnt_d          = '0;
                    hi_d           = '0;
                end else begin
                    // An aligned edge at cnt == 0 lands here and starts the period normally.
                    cnt_d = cnt_q + PW'(1);
                    hi_d  = hi_q + PW'(pwm_s);
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        n_d         = n_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (clear_avg) begin
            acc_d = '0;
            n_d   = '0;
        end else if (sample_valid_q) begin
            n_d = n_q + AVG_LOG2'(1);
            if (n_q == '1) begin
                avg_d       = acc_q + AW'(sample_q);
                avg_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + AW'(sample_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StHunt;
            cnt_q          <= '0;
            hi_q           <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            slip_q         <= 1'b0;
            acc_q          <= '0;
            n_q            <= '0;
            avg_q          <= '0;
            avg_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            locked_q       <= locked_d;
            slip_q         <= slip_d;
            acc_q          <= acc_d;
            n_q            <= n_d;
            avg_q          <= avg_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign avg          = avg_q;
    assign avg_valid    = avg_valid_q;
    assign locked       = locked_q;
    assign slip         = slip_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Scoreboard bench for pwm_demod (PW=4, AVG_LOG2=2, SYNC_STAGES=2).
// The stream is built from segments {duty, length}: a 16-clock segment is a full
// period and must yield sample == duty; a shorter segment is cut off by the next
// segment's rising edge and must yield a slip and restart the 4-sample average.
module tb_pwm_demod;

    localparam int unsigned PW          = 4;
    localparam int unsigned AVG_LOG2    = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          PERIOD      = 1 << PW;
    localparam int          NAVG        = 1 << AVG_LOG2;

    logic                   clk    = 1'b0;
    logic                   rst_n  = 1'b0;
    logic                   pwm_in = 1'b0;
    logic [PW-1:0]          sample;
    logic                   sample_valid;
    logic [PW+AVG_LOG2-1:0] avg;
    logic                   avg_valid;
    logic                   locked;
    logic                   slip;

    pwm_demod #(
        .PW         (PW),
        .AVG_LOG2   (AVG_LOG2),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .sample      (sample),
        .sample_valid(sample_valid),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .locked      (locked),
        .slip        (slip)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    bit arm_rise = 1'b0;
    bit seen_first = 1'b0;

    int exp_sample_q[$];
    int exp_avg_q[$];
    int exp_slip_q[$];
    int win[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_first = 1'b0;
        end else begin
            if (sample_valid) begin
                if (!seen_first) begin
                    // pwm_in rose in the clock after edge rise_cyc; counting that clock
                    // as clock 1, sample_valid occupies clock 2^PW+SYNC_STAGES+1.
                    check("first-sample latency", cyc - rise_cyc, PERIOD + SYNC_STAGES);
                    seen_first = 1'b1;
                end
                if (exp_sample_q.size() == 0) begin
                    check("spurious sample_valid", sample_valid, 0);
                end else begin
                    check("sample", sample, exp_sample_q.pop_front());
                    check("locked with sample", locked, 1);
                end
            end
            if (avg_valid) begin
                if (exp_avg_q.size() == 0) check("spurious avg_valid", avg_valid, 0);
                else check("avg", avg, exp_avg_q.pop_front());
            end
            if (slip) begin
                if (exp_slip_q.size() == 0) begin
                    check("spurious slip", slip, 0);
                end else begin
                    void'(exp_slip_q.pop_front());
                    check("locked after slip", locked, 0);
                end
            end
        end
    end

    // Reference model: one entry per segment, from the period-level rules only.
    task automatic model_seg(input int val, input int len);
        int s;
        if (len == PERIOD) begin
            exp_sample_q.push_back(val);
            win.push_back(val);
            if (win.size() == NAVG) begin
                s = 0;
                foreach (win[i]) s += win[i];
                exp_avg_q.push_back(s);
                win.delete();
            end
        end else begin
            exp_slip_q.push_back(1);
            win.delete();
        end
    endtask

    task automatic play_seg(input int val, input int len);
        model_seg(val, len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1 pwm_in = (c < val);
            if (c == 0 && val > 0 && arm_rise) begin
                rise_cyc = cyc;
                arm_rise = 1'b0;
            end
        end
    endtask

    // Low tail shorter than a period: flushes pending outputs without a new sample.
    task automatic tail();
        for (int c = 0; c < PERIOD / 2; c++) begin
            @(posedge clk);
            #1 pwm_in = 1'b0;
        end
    endtask

    task automatic do_reset(input bit toggle);
        @(posedge clk);
        #3;
        check("sample queue drained", exp_sample_q.size(), 0);
        check("avg queue drained", exp_avg_q.size(), 0);
        check("slip queue drained", exp_slip_q.size(), 0);
        rst_n = 1'b0;
        #1 check("outputs at reset assertion", {sample, sample_valid, avg, avg_valid,
                                               locked, slip}, 0);
        exp_sample_q.delete();
        exp_avg_q.delete();
        exp_slip_q.delete();
        win.delete();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 pwm_in = toggle ? ~pwm_in : 1'b0;
            @(negedge clk);
            check("outputs held in reset", {sample, sample_valid, avg, avg_valid,
                                            locked, slip}, 0);
        end
        pwm_in = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        arm_rise = 1'b1;
        for (int c = 0; c < 3; c++) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_trunc;
        int v;
        int l;

        // Reset with a toggling input, then a steady duty of 5.
        do_reset(1'b1);
        repeat (6) play_seg(5, PERIOD);
        tail();

        // Dither 5,6,5,6 and the largest duty.
        do_reset(1'b0);
        play_seg(5, PERIOD); play_seg(6, PERIOD); play_seg(5, PERIOD); play_seg(6, PERIOD);
        play_seg(15, PERIOD); play_seg(15, PERIOD);
        tail();

        // Duty 0 after lock: free-running, zero samples, no slip.
        do_reset(1'b0);
        play_seg(5, PERIOD); play_seg(0, PERIOD); play_seg(0, PERIOD); play_seg(0, PERIOD);
        play_seg(7, PERIOD);
        tail();

        // Rising edge 7 clocks into a period, then four fresh samples.
        do_reset(1'b0);
        play_seg(5, PERIOD); play_seg(5, PERIOD); play_seg(5, 7);
        repeat (4) play_seg(5, PERIOD);
        tail();

        // Reset mid-period with two samples in the averager; only post-reset samples count.
        do_reset(1'b0);
        play_seg(9, PERIOD); play_seg(9, PERIOD);
        tail();
        do_reset(1'b0);
        repeat (4) play_seg(9, PERIOD);
        tail();

        // Random duties with occasional early edges.
        do_reset(1'b0);
        prev_trunc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!prev_trunc && $urandom_range(0, 5) == 0) begin
                l = $urandom_range(2, PERIOD - 1);
                v = $urandom_range(1, l - 1);
                prev_trunc = 1'b1;
            end else begin
                l = PERIOD;
                v = prev_trunc ? $urandom_range(1, PERIOD - 1) : $urandom_range(0, PERIOD - 1);
                prev_trunc = 1'b0;
            end
            play_seg(v, l);
        end
        // A truncated last segment still needs the following edge to register the slip.
        if (prev_trunc) play_seg(3, PERIOD);
        tail();
        do_reset(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
